// File: rtl/game_pkg.sv
// Shared definitions for the jump game controller: FSM states, LFSR constants,
// block spacing and jump trajectory constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHARGE = 3'd2,
    ST_JUMP   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  // Fibonacci LFSR, taps at bits 16,14,13,11 (1-based) -> mask bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Minimum horizontal distance from block1 to block2
  localparam logic [9:0] BLOCK_GAP = 10'd96;

  // Jump trajectory: vy starts at +8 and falls by 1 per frame; 17 frames return to ground
  localparam logic signed [4:0] JUMP_VY0   = 5'sd8;
  localparam logic [4:0]        JUMP_TICKS = 5'd17;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length LFSR used for block placement and type.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_q
);

  // Advance one step every clock; a non-zero seed keeps it out of the all-zero state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= LFSR_SEED;
    else     o_q <= lfsr_next(o_q);
  end

endmodule

// File: rtl/game_ctrl.sv
// Jump game controller: frame-paced FSM that charges a jump while the button is
// held, flies the man along a fixed parabola and scores landings on block2.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] X_LEFT           = 10'd40,
  parameter logic [9:0] Y_GROUND         = 10'd300,
  parameter logic [9:0] BLOCK_W          = 10'd64,
  parameter logic [3:0] FRAMES_PER_LEVEL = 4'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vs,
  input  logic       i_btn,
  output logic       o_title,
  output logic       o_gameover,
  output logic [9:0] o_x_man,
  output logic [9:0] o_y_man,
  output logic [3:0] o_squeeze_man,
  output logic [9:0] o_x_block1,
  output logic [9:0] o_x_block2,
  output logic [3:0] o_type_block1,
  output logic [3:0] o_type_block2,
  output logic       o_en_block1,
  output logic       o_en_block2,
  output logic [7:0] o_score
);

  localparam logic [9:0] X_SPAWN = X_LEFT + (BLOCK_W >> 1);

  logic              vs_meta, vs_sync, vs_prev;
  logic              tick;
  logic              btn_prev;
  logic              press;
  state_t            state, state_next;
  logic [3:0]        squeeze;
  logic [3:0]        frame_cnt;
  logic [3:0]        step;
  logic signed [4:0] vy;
  logic [4:0]        jump_cnt;
  logic [9:0]        x_man, y_man, x_block2;
  logic [3:0]        type_block1, type_block2;
  logic [7:0]        score;
  logic [15:0]       lfsr_q;
  logic              on_block1, on_block2;
  logic              unused_lfsr;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .o_q (lfsr_q)
  );

  // Only bits [6:0] (block2 offset) and [11:8] (block2 type) are consumed
  assign unused_lfsr = ^{lfsr_q[15:12], lfsr_q[7]};

  // Two-flop vsync synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= i_vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign tick = vs_prev & ~vs_sync;

  // Button level remembered at each frame tick so a press is a low-to-high between ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       btn_prev <= 1'b0;
    else if (tick) btn_prev <= i_btn;
  end

  assign press     = i_btn & ~btn_prev;
  assign on_block1 = (x_man >= X_LEFT)   && (x_man <= X_LEFT + BLOCK_W - 10'd1);
  assign on_block2 = (x_man >= x_block2) && (x_man <= x_block2 + BLOCK_W - 10'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_TITLE;
    else     state <= state_next;
  end

  // Next-state logic, evaluated only on frame ticks
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        ST_TITLE:  if (press)  state_next = ST_IDLE;
        ST_IDLE:   if (i_btn)  state_next = ST_CHARGE;
        ST_CHARGE: if (!i_btn) state_next = ST_JUMP;
        ST_JUMP:   if (jump_cnt == JUMP_TICKS - 5'd1) state_next = ST_CHECK;
        ST_CHECK:  state_next = (on_block2 || on_block1) ? ST_IDLE : ST_OVER;
        ST_OVER:   if (press)  state_next = ST_TITLE;
        default:   state_next = ST_TITLE;
      endcase
    end
  end

  // Game datapath: pose, blocks, charge and jump registers, all frame-paced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squeeze     <= 4'd0;
      frame_cnt   <= 4'd0;
      step        <= 4'd0;
      vy          <= 5'sd0;
      jump_cnt    <= 5'd0;
      x_man       <= X_SPAWN;
      y_man       <= Y_GROUND;
      x_block2    <= X_LEFT + BLOCK_GAP;
      type_block1 <= 4'd0;
      type_block2 <= 4'd0;
      score       <= 8'd0;
    end else if (tick) begin
      case (state)
        ST_TITLE: begin
          if (press) begin
            x_man    <= X_SPAWN;
            y_man    <= Y_GROUND;
            x_block2 <= X_LEFT + BLOCK_GAP + {3'd0, lfsr_q[6:0]};
            score    <= 8'd0;
          end
        end
        ST_IDLE: begin
          if (i_btn) begin
            squeeze   <= 4'd0;
            frame_cnt <= 4'd0;
          end
        end
        ST_CHARGE: begin
          if (!i_btn) begin
            step     <= squeeze;
            vy       <= JUMP_VY0;
            jump_cnt <= 5'd0;
          end else if (frame_cnt == FRAMES_PER_LEVEL - 4'd1) begin
            frame_cnt <= 4'd0;
            squeeze   <= sat_inc4(squeeze);
          end else begin
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        ST_JUMP: begin
          x_man    <= x_man + {6'd0, step};
          y_man    <= y_man - {{5{vy[4]}}, vy};
          vy       <= vy - 5'sd1;
          jump_cnt <= jump_cnt + 5'd1;
        end
        ST_CHECK: begin
          if (on_block2) begin
            score       <= sat_inc8(score);
            x_man       <= x_man - (x_block2 - X_LEFT);
            type_block1 <= type_block2;
            x_block2    <= X_LEFT + BLOCK_GAP + {3'd0, lfsr_q[6:0]};
            type_block2 <= lfsr_q[11:8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from state and datapath registers
  always_comb begin
    o_title       = (state == ST_TITLE);
    o_gameover    = (state == ST_OVER);
    o_en_block1   = (state != ST_TITLE);
    o_en_block2   = (state != ST_TITLE);
    o_squeeze_man = (state == ST_CHARGE) ? squeeze : 4'd0;
    o_x_man       = x_man;
    o_y_man       = y_man;
    o_x_block1    = X_LEFT;
    o_x_block2    = x_block2;
    o_type_block1 = type_block1;
    o_type_block2 = type_block2;
    o_score       = score;
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: frame-level reference model of the game rules driven by
// directed scenarios and randomized jump strengths.
module tb_game_ctrl;

  logic       clk, rst, i_vs, i_btn;
  logic       o_title, o_gameover;
  logic [9:0] o_x_man, o_y_man;
  logic [3:0] o_squeeze_man;
  logic [9:0] o_x_block1, o_x_block2;
  logic [3:0] o_type_block1, o_type_block2;
  logic       o_en_block1, o_en_block2;
  logic [7:0] o_score;

  game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_vs          (i_vs),
    .i_btn         (i_btn),
    .o_title       (o_title),
    .o_gameover    (o_gameover),
    .o_x_man       (o_x_man),
    .o_y_man       (o_y_man),
    .o_squeeze_man (o_squeeze_man),
    .o_x_block1    (o_x_block1),
    .o_x_block2    (o_x_block2),
    .o_type_block1 (o_type_block1),
    .o_type_block2 (o_type_block2),
    .o_en_block1   (o_en_block1),
    .o_en_block2   (o_en_block2),
    .o_score       (o_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // clock cycles since reset release; the LFSR has advanced exactly this many times
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [15:0] lc_val;
  int          lc_n;
  logic [15:0] tick_lfsr;

  task automatic get_lfsr(input int n, output logic [15:0] v);
    if (n < lc_n) begin
      lc_val = 16'hACE1;
      lc_n   = 0;
    end
    while (lc_n < n) begin
      lc_val = {lc_val[14:0], lc_val[15] ^ lc_val[13] ^ lc_val[12] ^ lc_val[10]};
      lc_n++;
    end
    v = lc_val;
  endtask

  // reference model, one step per frame
  localparam int M_TITLE = 0, M_READY = 1, M_CHARGE = 2, M_AIR = 3, M_LAND = 4, M_OVER = 5;
  int m_mode, m_x, m_y, m_x0, m_b2, m_t1, m_t2, m_score, m_n, m_k, m_step;
  bit m_prev_btn;

  task automatic model_reset();
    m_mode = M_TITLE; m_x = 72; m_y = 300; m_x0 = 72; m_b2 = 136;
    m_t1 = 0; m_t2 = 0; m_score = 0; m_n = 0; m_k = 0; m_step = 0; m_prev_btn = 1'b0;
  endtask

  task automatic model_step(input bit btn);
    bit press;
    press = btn && !m_prev_btn;
    m_prev_btn = btn;
    case (m_mode)
      M_TITLE: if (press) begin
        m_mode = M_READY; m_x = 72; m_y = 300; m_score = 0;
        m_b2 = 136 + int'(tick_lfsr[6:0]);
      end
      M_READY: if (btn) begin m_mode = M_CHARGE; m_n = 0; end
      M_CHARGE: if (!btn) begin
        m_mode = M_AIR; m_step = (m_n / 6 > 15) ? 15 : m_n / 6; m_k = 0; m_x0 = m_x;
      end else m_n++;
      M_AIR: begin
        m_k++;
        m_x = m_x0 + m_step * m_k;
        m_y = 300 - (8 * m_k - (m_k * (m_k - 1)) / 2);
        if (m_k == 17) m_mode = M_LAND;
      end
      M_LAND: begin
        if (m_x >= m_b2 && m_x < m_b2 + 64) begin
          m_score = (m_score == 255) ? 255 : m_score + 1;
          m_x = m_x - (m_b2 - 40);
          m_t1 = m_t2;
          m_b2 = 136 + int'(tick_lfsr[6:0]);
          m_t2 = int'(tick_lfsr[11:8]);
          m_mode = M_READY;
        end else if (m_x >= 40 && m_x < 104) m_mode = M_READY;
        else m_mode = M_OVER;
      end
      M_OVER: if (press) m_mode = M_TITLE;
      default: m_mode = M_TITLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sq;
    sq = (m_mode == M_CHARGE) ? ((m_n / 6 > 15) ? 15 : m_n / 6) : 0;
    chk({tag, ":title"},    16'(o_title),       16'(m_mode == M_TITLE));
    chk({tag, ":gameover"}, 16'(o_gameover),    16'(m_mode == M_OVER));
    chk({tag, ":x_man"},    16'(o_x_man),       16'(m_x));
    chk({tag, ":y_man"},    16'(o_y_man),       16'(m_y));
    chk({tag, ":squeeze"},  16'(o_squeeze_man), 16'(sq));
    chk({tag, ":x_block1"}, 16'(o_x_block1),    16'd40);
    chk({tag, ":x_block2"}, 16'(o_x_block2),    16'(m_b2));
    chk({tag, ":type1"},    16'(o_type_block1), 16'(m_t1));
    chk({tag, ":type2"},    16'(o_type_block2), 16'(m_t2));
    chk({tag, ":en1"},      16'(o_en_block1),   16'(m_mode != M_TITLE));
    chk({tag, ":en2"},      16'(o_en_block2),   16'(m_mode != M_TITLE));
    chk({tag, ":score"},    16'(o_score),       16'(m_score));
  endtask

  // one vsync pulse with the button held at btn; entered and left on a negedge
  task automatic frame(input bit btn);
    i_btn = btn;
    i_vs  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    get_lfsr(cyc, tick_lfsr);
    @(negedge clk);
    i_vs = 1'b1;
    repeat (3) @(negedge clk);
    model_step(btn);
    check_all("frame");
  endtask

  task automatic do_jump(input int s);
    frame(1'b1);
    repeat (6 * s) frame(1'b1);
    frame(1'b0);
    repeat (17) frame(1'b0);
    frame(1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ymin, r, s, smin, smax;
    n_checks = 0; n_fail = 0;
    lc_val = 16'hACE1; lc_n = 0; tick_lfsr = 16'hACE1;
    i_vs = 1'b1; i_btn = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    check_all("reset");
    chk("reset_x_man", 16'(o_x_man), 16'd72);
    chk("reset_x_block2", 16'(o_x_block2), 16'd136);
    rst = 1'b0;
    @(negedge clk);

    // title exits on a press at the third tick
    frame(1'b0);
    frame(1'b0);
    chk("title_tick2", 16'(o_title), 16'd1);
    frame(1'b1);
    chk("title_tick3", 16'(o_title), 16'd0);
    chk("en_tick3", 16'(o_en_block1), 16'd1);
    chk("x_man_tick3", 16'(o_x_man), 16'd72);
    chk("y_man_tick3", 16'(o_y_man), 16'd300);

    // charge levels while held, then saturation
    for (int i = 0; i < 20; i++) begin
      frame(1'b1);
      if (i == 5) chk("squeeze_t5", 16'(o_squeeze_man), 16'd0);
      if (i == 6) chk("squeeze_t6", 16'(o_squeeze_man), 16'd1);
      if (i == 18) chk("squeeze_t18", 16'(o_squeeze_man), 16'd3);
    end
    repeat (81) frame(1'b1);
    chk("squeeze_sat", 16'(o_squeeze_man), 16'd15);

    // full-strength jump overshoots every block
    frame(1'b0);
    chk("jump_squeeze0", 16'(o_squeeze_man), 16'd0);
    repeat (17) frame(1'b0);
    chk("far_x", 16'(o_x_man), 16'd327);
    chk("far_y", 16'(o_y_man), 16'd300);
    frame(1'b0);
    chk("far_gameover", 16'(o_gameover), 16'd1);
    frame(1'b1);
    chk("over_to_title", 16'(o_title), 16'd1);

    // new game, squeeze 4 jump trajectory
    frame(1'b0);
    frame(1'b1);
    frame(1'b1);
    repeat (24) frame(1'b1);
    chk("squeeze4", 16'(o_squeeze_man), 16'd4);
    frame(1'b0);
    ymin = 1023;
    for (int k = 0; k < 17; k++) begin
      frame(1'b0);
      if (int'(o_y_man) < ymin) ymin = int'(o_y_man);
    end
    chk("s4_x", 16'(o_x_man), 16'd140);
    chk("s4_y", 16'(o_y_man), 16'd300);
    chk("s4_ymin", 16'(ymin), 16'd264);
    frame(1'b0);

    // randomized play, mostly aimed at block2
    for (int round = 0; round < 16; round++) begin
      if (m_mode != M_READY) begin
        frame(1'b0);
        frame(1'b1);
      end else begin
        r = int'($urandom_range(0, 9));
        smin = (m_b2 - m_x + 16) / 17;
        smax = (m_b2 + 63 - m_x) / 17;
        if (smax > 15) smax = 15;
        if (r == 0)      s = 0;
        else if (r == 1) s = int'($urandom_range(0, 15));
        else             s = int'($urandom_range(smax, smin));
        do_jump(s);
      end
    end

    // reset in the middle of a jump
    for (int g = 0; g < 4 && m_mode != M_READY; g++) begin
      frame(1'b0);
      frame(1'b1);
    end
    frame(1'b1);
    repeat (12) frame(1'b1);
    frame(1'b0);
    repeat (7) frame(1'b0);
    i_vs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid_jump");
    chk("rst_mid_jump_title", 16'(o_title), 16'd1);
    @(negedge clk);
    i_vs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // no vsync activity: nothing moves whatever the button does
    for (int i = 0; i < 40; i++) begin
      i_btn = ~i_btn;
      @(negedge clk);
      if (i % 8 == 0) check_all("vs_idle");
    end
    i_btn = 1'b0;
    @(negedge clk);

    // reset in the middle of a charge, then a zero-step jump lands in place
    frame(1'b1);
    frame(1'b1);
    repeat (10) frame(1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid_charge");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(1'b0);
    frame(1'b1);
    do_jump(0);
    chk("step0_x", 16'(o_x_man), 16'd72);
    chk("step0_gameover", 16'(o_gameover), 16'd0);
    chk("step0_en", 16'(o_en_block1), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
